mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one unified single-port memory between the core's instruction-fetch port and data load/store port.
- Fixed priority: data before fetch, since the data access belongs to the older instruction.
- Memory side uses a req/ack handshake with variable latency; the arbiter stalls the core until each access completes.
- Sits between the riscv core and the memory, replacing separate imem/dmem.

Parameters:
TIMEOUT, 255, max cycles waiting for m_ack before abort; 0 disables the timeout
STARVE_MAX, 4, consecutive fetch losses before fetch is forced (used only with the optional feature)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
i_req  input  1  fetch request; held until i_ack
i_addr  input  32  fetch address
i_rdata  output  32  fetch data; valid while i_ack=1
i_ack  output  1  fetch completion, one cycle
d_req  input  1  data request; held until d_ack
d_we  input  1  1=store, 0=load
d_addr  input  32  data address
d_wdata  input  32  store data
d_rdata  output  32  load data; valid while d_ack=1
d_ack  output  1  data completion, one cycle
m_req  output  1  memory request
m_we  output  1  memory write enable
m_addr  output  32  memory address
m_wdata  output  32  memory write data
m_rdata  input  32  memory read data; valid with m_ack
m_ack  input  1  memory completion
err  output  1  one-cycle pulse with the x_ack of a timed-out access
stall  output  1  core stall

Behaviour:
- States: IDLE, GNT_I, GNT_D.
- Registers: latched addr/we/wdata, wait counter (8+ bits, sized for TIMEOUT), starvation counter.
- Reset (sync): state=IDLE; latched regs=0; counters=0.
  - All outputs 0 except stall, which follows its equation.
- Reset mid-transaction: state returns to IDLE at that edge; no ack and no err issued; m_req low next cycle.
- IDLE:
  - d_req=1 -> GNT_D; latch d_addr, d_we, d_wdata.
  - else i_req=1 -> GNT_I; latch i_addr; we=0; wdata=0.
  - else stay.
  - Simultaneous i_req and d_req: D wins.
- GNT_x:
  - m_req=1; m_addr/m_we/m_wdata driven from latched regs.
  - Wait counter increments each cycle without m_ack; starts at 0 on entry.
- Completion (same cycle as m_ack in GNT_x):
  - x_ack=1 combinationally; x_rdata=m_rdata (pass-through).
  - Stores still pulse d_ack; d_rdata=m_rdata, don't-care.
  - Next state IDLE.
- Timeout: TIMEOUT!=0 and counter==TIMEOUT-1 with no m_ack:
  - x_ack=1, err=1, x_rdata=0 that cycle; next state IDLE.
  - A late m_ack arriving in IDLE is ignored.
- Ack gating:
  - m_ack outside GNT_x: ignored.
  - i_ack only in GNT_I, d_ack only in GNT_D; never both.
- x_rdata is 0 whenever x_ack=0.
- Requester dropping req mid-grant: the access still completes and x_ack still pulses.
- Latency and throughput:
  - Request seen in IDLE at cycle 0; m_req from cycle 1; x_ack in the cycle of m_ack (earliest cycle 1).
  - Back-to-back: one IDLE cycle between grants, so minimum 2 cycles per access.
- stall = (i_req & ~i_ack) | (d_req & ~d_ack), combinational.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - Starvation counter increments at each IDLE arbitration where i_req=1 and D wins.
  - Counter clears on any GNT_I entry.
  - When counter==STARVE_MAX and i_req=1, IDLE grants I even if d_req=1.
  - Counter saturates at STARVE_MAX.
- Undefined: pure fixed priority; the counter is not built.

Test Plan:
- Fetch only: i_req=1, i_addr=0x00000010, memory acks 3 cycles after m_req with 0x20020005 -> m_addr=0x10, m_we=0; i_ack one cycle with i_rdata=0x20020005; stall=1 until that cycle.
- Store with simultaneous fetch: d_req=1, d_we=1, d_addr=0x54, d_wdata=7, i_req=1 -> GNT_D first: m_we=1, m_wdata=7. After d_ack, one IDLE cycle, then GNT_I with m_addr=i_addr.
- Timeout, TIMEOUT=4: memory never acks -> i_ack=1, err=1, i_rdata=0 at the 4th m_req cycle. A later m_ack produces no ack.
- Reset during GNT_D: reset=1 for one cycle mid-wait -> no d_ack; state IDLE; m_req=0 next cycle; later m_ack ignored.
- Zero-wait memory: m_ack tied high, continuous i_req -> i_ack every 2nd cycle, ack aligned with m_req cycle.
- ARB_STARVE_GUARD_EN, STARVE_MAX=4: d_req and i_req held high -> 4 D grants, then 1 I grant, repeating. Without the macro: I never granted.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port memory between the core's instruction-fetch port
//   (i_*) and data load/store port (d_*). Data wins over fetch because it
//   belongs to the older instruction. The memory side is a req/ack handshake
//   with variable latency; the core is stalled until its access completes.
//   An access whose m_ack has not arrived after TIMEOUT grant cycles is
//   aborted with err=1 (TIMEOUT=0 disables this).
//
//   Optional build macro ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive
//   arbitrations lost by a pending fetch, the next arbitration grants fetch.
//   With the macro undefined the arbiter is pure fixed priority.
//
// Ports
//   clk, reset                    clock (rising edge), synchronous active-high reset
//   i_req/i_addr -> i_rdata/i_ack fetch request and one-cycle completion
//   d_req/d_we/d_addr/d_wdata
//                -> d_rdata/d_ack data request and one-cycle completion
//   m_req/m_we/m_addr/m_wdata     memory request, held for the whole grant
//   m_rdata/m_ack                 memory read data and completion
//   err                           pulses with the x_ack of a timed-out access
//   stall                         core stall, combinational
module mem_arbiter #(
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        err,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             timeout_hit;
    logic             done;
    logic             force_i;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q, starve_d;

    assign force_i = i_req && (starve_q == STARVE_LIM);
`else
    logic unused_starve_max;

    assign unused_starve_max = (STARVE_MAX != 0);
    assign force_i           = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT != 0) && (wcnt_q == WAIT_LAST);
    // m_ack takes precedence over a timeout landing on the same cycle
    assign done        = m_ack || timeout_hit;

    assign m_req   = (state_q != IDLE);
    assign m_we    = we_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        wcnt_d  = wcnt_q;
        i_ack   = 1'b0;
        d_ack   = 1'b0;
        i_rdata = '0;
        d_rdata = '0;
        err     = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        starve_d = starve_q;
`endif
        case (state_q)
            IDLE: begin
                wcnt_d = '0;
                if (d_req && !force_i) begin
                    state_d = GNT_D;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
`ifdef ARB_STARVE_GUARD_EN
                    if (i_req && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + 1'b1;
                    end
`endif
                end else if (i_req) begin
                    state_d = GNT_I;
                    addr_d  = i_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
`ifdef ARB_STARVE_GUARD_EN
                    starve_d = '0;
`endif
                end
            end
            GNT_I, GNT_D: begin
                if (done) begin
                    state_d = IDLE;
                    // A reset on this edge discards the completion entirely
                    if (!reset) begin
                        if (state_q == GNT_I) begin
                            i_ack   = 1'b1;
                            i_rdata = m_ack ? m_rdata : '0;
                        end else begin
                            d_ack   = 1'b1;
                            d_rdata = m_ack ? m_rdata : '0;
                        end
                        err = !m_ack;
                    end
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            wcnt_q  <= '0;
`ifdef ARB_STARVE_GUARD_EN
            starve_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            wcnt_q  <= wcnt_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_q <= starve_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        err;
    logic        stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .TIMEOUT   (4),
        .STARVE_MAX(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .i_req  (i_req),
        .i_addr (i_addr),
        .i_rdata(i_rdata),
        .i_ack  (i_ack),
        .d_req  (d_req),
        .d_we   (d_we),
        .d_addr (d_addr),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_ack  (d_ack),
        .m_req  (m_req),
        .m_we   (m_we),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_rdata(m_rdata),
        .m_ack  (m_ack),
        .err    (err),
        .stall  (stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then changed
    // and outputs sampled #1 later, well away from the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic exp_i;
        reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        m_rdata = '0;
        m_ack   = 1'b0;

        // ---------------- reset state
        cyc(); cyc(); settle();
        chk("rst_m_req", {31'd0, m_req}, 32'd0);
        chk("rst_i_ack", {31'd0, i_ack}, 32'd0);
        chk("rst_d_ack", {31'd0, d_ack}, 32'd0);
        chk("rst_err",   {31'd0, err},   32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_m_we",  {31'd0, m_we},  32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        reset = 1'b0;
        cyc();

        // ---------------- fetch only, ack on the 4th m_req cycle
        i_req  = 1'b1;
        i_addr = 32'h0000_0010;
        settle();
        chk("f_idle_stall", {31'd0, stall}, 32'd1);
        chk("f_idle_mreq",  {31'd0, m_req}, 32'd0);
        cyc(); settle();
        chk("f_c1_mreq",  {31'd0, m_req}, 32'd1);
        chk("f_c1_maddr", m_addr, 32'h10);
        chk("f_c1_mwe",   {31'd0, m_we}, 32'd0);
        chk("f_c1_iack",  {31'd0, i_ack}, 32'd0);
        chk("f_c1_stall", {31'd0, stall}, 32'd1);
        cyc(); settle();
        chk("f_c2_iack", {31'd0, i_ack}, 32'd0);
        cyc(); settle();
        chk("f_c3_iack",  {31'd0, i_ack}, 32'd0);
        chk("f_c3_stall", {31'd0, stall}, 32'd1);
        cyc();
        m_ack   = 1'b1;
        m_rdata = 32'h2002_0005;
        settle();
        chk("f_c4_iack",   {31'd0, i_ack}, 32'd1);
        chk("f_c4_irdata", i_rdata, 32'h2002_0005);
        chk("f_c4_err",    {31'd0, err}, 32'd0);
        chk("f_c4_dack",   {31'd0, d_ack}, 32'd0);
        chk("f_c4_stall",  {31'd0, stall}, 32'd0);
        cyc();
        i_req = 1'b0;
        m_ack = 1'b0;
        settle();
        chk("f_post_mreq",   {31'd0, m_req}, 32'd0);
        chk("f_post_iack",   {31'd0, i_ack}, 32'd0);
        chk("f_post_irdata", i_rdata, 32'd0);

        // ---------------- store with simultaneous fetch
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h54;
        d_wdata = 32'd7;
        i_req   = 1'b1;
        i_addr  = 32'h100;
        settle();
        chk("sd_idle_stall", {31'd0, stall}, 32'd1);
        cyc(); settle();
        chk("sd_gd_mreq",   {31'd0, m_req}, 32'd1);
        chk("sd_gd_mwe",    {31'd0, m_we}, 32'd1);
        chk("sd_gd_mwdata", m_wdata, 32'd7);
        chk("sd_gd_maddr",  m_addr, 32'h54);
        m_ack   = 1'b1;
        m_rdata = 32'h0000_DEAD;
        settle();
        chk("sd_dack",  {31'd0, d_ack}, 32'd1);
        chk("sd_iack0", {31'd0, i_ack}, 32'd0);
        cyc();
        d_req = 1'b0;
        m_ack = 1'b0;
        settle();
        chk("sd_gap_mreq",  {31'd0, m_req}, 32'd0);
        chk("sd_gap_stall", {31'd0, stall}, 32'd1);
        cyc(); settle();
        chk("sd_gi_mreq",   {31'd0, m_req}, 32'd1);
        chk("sd_gi_maddr",  m_addr, 32'h100);
        chk("sd_gi_mwe",    {31'd0, m_we}, 32'd0);
        chk("sd_gi_mwdata", m_wdata, 32'd0);
        m_ack   = 1'b1;
        m_rdata = 32'h0000_1234;
        settle();
        chk("sd_gi_iack",   {31'd0, i_ack}, 32'd1);
        chk("sd_gi_irdata", i_rdata, 32'h1234);
        chk("sd_gi_dack",   {31'd0, d_ack}, 32'd0);
        chk("sd_gi_drdata", d_rdata, 32'd0);
        cyc();
        i_req = 1'b0;
        m_ack = 1'b0;

        // ---------------- timeout (TIMEOUT=4)
        i_req   = 1'b1;
        i_addr  = 32'h200;
        m_rdata = 32'hFFFF_FFFF;
        cyc(); settle();
        chk("to_c1_mreq", {31'd0, m_req}, 32'd1);
        chk("to_c1_iack", {31'd0, i_ack}, 32'd0);
        cyc(); cyc(); settle();
        chk("to_c3_iack", {31'd0, i_ack}, 32'd0);
        chk("to_c3_err",  {31'd0, err}, 32'd0);
        cyc(); settle();
        chk("to_c4_iack",   {31'd0, i_ack}, 32'd1);
        chk("to_c4_err",    {31'd0, err}, 32'd1);
        chk("to_c4_irdata", i_rdata, 32'd0);
        cyc();
        i_req = 1'b0;
        m_ack = 1'b1;
        settle();
        chk("to_late_mreq", {31'd0, m_req}, 32'd0);
        chk("to_late_iack", {31'd0, i_ack}, 32'd0);
        chk("to_late_err",  {31'd0, err}, 32'd0);
        cyc(); settle();
        chk("to_late2_iack", {31'd0, i_ack}, 32'd0);
        chk("to_late2_dack", {31'd0, d_ack}, 32'd0);
        m_ack = 1'b0;

        // ---------------- reset during GNT_D
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h80;
        cyc(); settle();
        chk("rg_mreq", {31'd0, m_req}, 32'd1);
        chk("rg_maddr", m_addr, 32'h80);
        cyc();
        reset = 1'b1;
        settle();
        chk("rg_rst_dack", {31'd0, d_ack}, 32'd0);
        cyc();
        reset = 1'b0;
        d_req = 1'b0;
        settle();
        chk("rg_after_mreq", {31'd0, m_req}, 32'd0);
        m_ack   = 1'b1;
        m_rdata = 32'h0000_0042;
        settle();
        chk("rg_late_dack", {31'd0, d_ack}, 32'd0);
        chk("rg_late_err",  {31'd0, err}, 32'd0);
        cyc(); settle();
        chk("rg_late2_mreq", {31'd0, m_req}, 32'd0);
        chk("rg_late2_dack", {31'd0, d_ack}, 32'd0);

        // ---------------- zero-wait memory, continuous fetch (m_ack still high)
        m_rdata = 32'h0000_0055;
        i_req   = 1'b1;
        i_addr  = 32'h0000_0400;
        settle();
        chk("zw_0_iack", {31'd0, i_ack}, 32'd0);
        chk("zw_0_mreq", {31'd0, m_req}, 32'd0);
        for (int n = 1; n <= 6; n++) begin
            cyc(); settle();
            exp_i = (n % 2) == 1;
            chk($sformatf("zw_%0d_iack", n), {31'd0, i_ack}, {31'd0, exp_i});
            chk($sformatf("zw_%0d_mreq", n), {31'd0, m_req}, {31'd0, exp_i});
        end
        i_req = 1'b0;
        cyc();

        // ---------------- starvation: both requesters held, zero-wait memory
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h300;
        i_req  = 1'b1;
        i_addr = 32'h400;
        for (int g = 0; g < 10; g++) begin
            cyc(); settle();
`ifdef ARB_STARVE_GUARD_EN
            exp_i = (g % 5) == 4;
`else
            exp_i = 1'b0;
`endif
            chk($sformatf("sv_%0d_iack", g), {31'd0, i_ack}, {31'd0, exp_i});
            chk($sformatf("sv_%0d_dack", g), {31'd0, d_ack}, {31'd0, ~exp_i});
            cyc();
        end
        d_req = 1'b0;
        i_req = 1'b0;
        m_ack = 1'b0;
        cyc(); settle();
        chk("end_mreq", {31'd0, m_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
